// File: rtl/rotary_param_if.sv
// Bundles the encoder/button inputs and the parameter-bank outputs
// of rotary_param_ctrl so they travel as one port.
interface rotary_param_if #(
    parameter int N_PARAMS = 4,
    parameter int WIDTH    = 8
);
    localparam int SEL_W = $clog2(N_PARAMS);

    logic                      i_cnt;
    logic                      i_cnt_cw;
    logic                      i_btn;
    logic                      i_lock;
    logic [SEL_W-1:0]          o_sel;
    logic                      o_edit;
    logic [WIDTH-1:0]          o_value;
    logic [N_PARAMS*WIDTH-1:0] o_values;
    logic                      o_changed;

    // Source of encoder/button events, observer of the parameter bank.
    modport master (
        output i_cnt, i_cnt_cw, i_btn, i_lock,
        input  o_sel, o_edit, o_value, o_values, o_changed
    );

    // The controller itself.
    modport slave (
        input  i_cnt, i_cnt_cw, i_btn, i_lock,
        output o_sel, o_edit, o_value, o_values, o_changed
    );
endinterface

// File: rtl/rotary_param_ctrl.sv
// Shares one rotary encoder among N_PARAMS parameter registers.
// NAV: encoder moves the selection. EDIT: encoder changes the selected
// value with saturate/wrap bounds, speed acceleration and idle timeout.
module rotary_param_ctrl #(
    parameter int N_PARAMS     = 4,
    parameter int WIDTH        = 8,
    parameter int MIN_VAL      = 0,
    parameter int MAX_VAL      = 100,
    parameter int RESET_VAL    = 50,
    parameter int WRAP         = 0,
    parameter int ACCEL_WINDOW = 50000,
    parameter int ACCEL_STEP   = 4,
    parameter int IDLE_TIMEOUT = 10000000
) (
    input  logic           i_clk,
    input  logic           i_rst,
    rotary_param_if.slave  bus
);
    localparam int SEL_W  = $clog2(N_PARAMS);
    localparam int ACC_W  = $clog2(ACCEL_WINDOW + 1);
    localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);
    localparam int CALC_W = WIDTH + 2;

    typedef enum logic [0:0] {NAV, EDIT} state_t;

    state_t              state, state_nxt;
    logic [SEL_W-1:0]    sel, sel_nxt;
    logic [ACC_W-1:0]    acc_cnt, acc_nxt;
    logic                last_dir, last_dir_nxt;
    logic [IDLE_W-1:0]   idle_cnt, idle_nxt;
    logic                step_en;
    logic                changed;
    logic [WIDTH-1:0]    vals [N_PARAMS];

    logic                       fast;
    logic signed [CALC_W-1:0]   cur_s, step_s, raw_s;
    logic [WIDTH-1:0]           new_val;

    // Apply the bound policy to an unbounded step result. Wrapping jumps
    // to the opposite bound; any excess beyond the bound is dropped.
    function automatic logic [WIDTH-1:0] bound_val(input logic signed [CALC_W-1:0] raw);
        logic signed [CALC_W-1:0] lo, hi;
        lo = CALC_W'(MIN_VAL);
        hi = CALC_W'(MAX_VAL);
        if (raw > hi)
            return (WRAP != 0) ? WIDTH'(MIN_VAL) : WIDTH'(MAX_VAL);
        else if (raw < lo)
            return (WRAP != 0) ? WIDTH'(MAX_VAL) : WIDTH'(MIN_VAL);
        else
            return WIDTH'(raw);
    endfunction

    // Candidate new value for the selected parameter; two guard bits keep
    // the sum and difference free of overflow.
    always_comb begin
        fast    = (acc_cnt < ACC_W'(ACCEL_WINDOW)) && (bus.i_cnt_cw == last_dir);
        cur_s   = $signed({2'b00, vals[sel]});
        step_s  = fast ? CALC_W'(ACCEL_STEP) : CALC_W'(1);
        raw_s   = bus.i_cnt_cw ? (cur_s + step_s) : (cur_s - step_s);
        new_val = bound_val(raw_s);
    end

    // Next-state logic: button beats encoder, lock freezes everything.
    always_comb begin
        state_nxt    = state;
        sel_nxt      = sel;
        acc_nxt      = acc_cnt;
        last_dir_nxt = last_dir;
        idle_nxt     = idle_cnt;
        step_en      = 1'b0;
        if (!bus.i_lock) begin
            if (acc_cnt != ACC_W'(ACCEL_WINDOW))
                acc_nxt = acc_cnt + ACC_W'(1);
            case (state)
                NAV: begin
                    if (bus.i_btn) begin
                        state_nxt = EDIT;
                        idle_nxt  = '0;
                        acc_nxt   = ACC_W'(ACCEL_WINDOW);
                    end else if (bus.i_cnt) begin
                        if (bus.i_cnt_cw)
                            sel_nxt = (sel == SEL_W'(N_PARAMS - 1)) ? '0 : sel + SEL_W'(1);
                        else
                            sel_nxt = (sel == '0) ? SEL_W'(N_PARAMS - 1) : sel - SEL_W'(1);
                    end
                end
                EDIT: begin
                    if (bus.i_btn) begin
                        state_nxt = NAV;
                    end else if (bus.i_cnt) begin
                        step_en      = 1'b1;
                        acc_nxt      = '0;
                        last_dir_nxt = bus.i_cnt_cw;
                        idle_nxt     = '0;
                    end else if (idle_cnt == IDLE_W'(IDLE_TIMEOUT - 1)) begin
                        state_nxt = NAV;
                    end else begin
                        idle_nxt = idle_cnt + IDLE_W'(1);
                    end
                end
                default: state_nxt = NAV;
            endcase
        end
    end

    // Controller state, selection and timers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= NAV;
            sel      <= '0;
            acc_cnt  <= ACC_W'(ACCEL_WINDOW);
            last_dir <= 1'b0;
            idle_cnt <= '0;
        end else begin
            state    <= state_nxt;
            sel      <= sel_nxt;
            acc_cnt  <= acc_nxt;
            last_dir <= last_dir_nxt;
            idle_cnt <= idle_nxt;
        end
    end

    // Parameter bank and change pulse; a clamped step leaves the value alone
    // and therefore raises no pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < N_PARAMS; k++)
                vals[k] <= WIDTH'(RESET_VAL);
            changed <= 1'b0;
        end else if (step_en) begin
            vals[sel] <= new_val;
            changed   <= (new_val != vals[sel]);
        end else begin
            changed <= 1'b0;
        end
    end

    assign bus.o_sel     = sel;
    assign bus.o_edit    = (state == EDIT);
    assign bus.o_value   = vals[sel];
    assign bus.o_changed = changed;

    for (genvar k = 0; k < N_PARAMS; k++) begin : g_pack
        assign bus.o_values[k*WIDTH +: WIDTH] = vals[k];
    end
endmodule

// File: tb/tb_rotary_param_ctrl.sv
// Bench for rotary_param_ctrl: two instances (saturating and wrapping)
// driven by identical stimulus, compared every cycle to a behavioural model.
module tb_rotary_param_ctrl;
    localparam int NP = 4;
    localparam int W  = 8;
    localparam int MINV = 0;
    localparam int MAXV = 100;
    localparam int RSTV = 50;
    localparam int AW = 100;
    localparam int AS = 4;
    localparam int IT = 1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rotary_param_if #(.N_PARAMS(NP), .WIDTH(W)) if0 ();
    rotary_param_if #(.N_PARAMS(NP), .WIDTH(W)) if1 ();

    rotary_param_ctrl #(.N_PARAMS(NP), .WIDTH(W), .MIN_VAL(MINV), .MAX_VAL(MAXV),
        .RESET_VAL(RSTV), .WRAP(0), .ACCEL_WINDOW(AW), .ACCEL_STEP(AS),
        .IDLE_TIMEOUT(IT)) dut0 (.i_clk(clk), .i_rst(rst), .bus(if0));

    rotary_param_ctrl #(.N_PARAMS(NP), .WIDTH(W), .MIN_VAL(MINV), .MAX_VAL(MAXV),
        .RESET_VAL(RSTV), .WRAP(1), .ACCEL_WINDOW(AW), .ACCEL_STEP(AS),
        .IDLE_TIMEOUT(IT)) dut1 (.i_clk(clk), .i_rst(rst), .bus(if1));

    int n_cmp = 0;
    int n_err = 0;

    // Model: time measured in unlocked clock edges.
    int m_edit [2];
    int m_sel  [2];
    int m_vals [2][NP];
    int m_dir  [2];
    int m_last_step [2];
    int m_idle_ref  [2];
    int m_t    [2];
    int m_chg  [2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic mdl_edge(input int w, input bit r, lock, btn, cnt, cw);
        int step, v, old;
        if (r) begin
            m_edit[w] = 0; m_sel[w] = 0; m_dir[w] = 0; m_chg[w] = 0;
            m_last_step[w] = -1000000; m_idle_ref[w] = 0;
            for (int k = 0; k < NP; k++) m_vals[w][k] = RSTV;
            return;
        end
        m_chg[w] = 0;
        if (lock) return;
        m_t[w]++;
        if (m_edit[w] == 0) begin
            if (btn) begin
                m_edit[w] = 1;
                m_idle_ref[w] = m_t[w];
                m_last_step[w] = -1000000;
            end else if (cnt) begin
                m_sel[w] = cw ? (m_sel[w] + 1) % NP : (m_sel[w] + NP - 1) % NP;
            end
        end else begin
            if (btn) begin
                m_edit[w] = 0;
            end else if (cnt) begin
                step = ((m_t[w] - m_last_step[w] - 1) < AW && int'(cw) == m_dir[w]) ? AS : 1;
                old = m_vals[w][m_sel[w]];
                v = cw ? old + step : old - step;
                if (v > MAXV) v = (w == 1) ? MINV : MAXV;
                if (v < MINV) v = (w == 1) ? MAXV : MINV;
                m_vals[w][m_sel[w]] = v;
                m_chg[w] = (v != old) ? 1 : 0;
                m_last_step[w] = m_t[w];
                m_dir[w] = int'(cw);
                m_idle_ref[w] = m_t[w];
            end else if (m_t[w] - m_idle_ref[w] == IT) begin
                m_edit[w] = 0;
            end
        end
    endtask

    task automatic check_all();
        logic [NP*W-1:0] ev;
        for (int w = 0; w < 2; w++) begin
            for (int k = 0; k < NP; k++) ev[k*W +: W] = W'(m_vals[w][k]);
            chk($sformatf("w%0d_sel", w), (w == 0) ? 64'(if0.o_sel) : 64'(if1.o_sel), 64'(m_sel[w]));
            chk($sformatf("w%0d_edit", w), (w == 0) ? 64'(if0.o_edit) : 64'(if1.o_edit), 64'(m_edit[w]));
            chk($sformatf("w%0d_value", w), (w == 0) ? 64'(if0.o_value) : 64'(if1.o_value),
                64'(m_vals[w][m_sel[w]]));
            chk($sformatf("w%0d_values", w), (w == 0) ? 64'(if0.o_values) : 64'(if1.o_values), 64'(ev));
            chk($sformatf("w%0d_changed", w), (w == 0) ? 64'(if0.o_changed) : 64'(if1.o_changed),
                64'(m_chg[w]));
        end
    endtask

    task automatic cycle(input bit r, lock, btn, cnt, cw);
        rst = r;
        if0.i_lock = lock; if0.i_btn = btn; if0.i_cnt = cnt; if0.i_cnt_cw = cw;
        if1.i_lock = lock; if1.i_btn = btn; if1.i_cnt = cnt; if1.i_cnt_cw = cw;
        @(posedge clk);
        for (int w = 0; w < 2; w++) mdl_edge(w, r, lock, btn, cnt, cw);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // One encoder step ten cycles after the previous one.
    task automatic es(input bit cw);
        idle(9);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, cw);
    endtask

    initial begin
        logic [NP*W-1:0] snap;
        logic [7:0] v_before;
        logic [1:0] s_before;
        for (int w = 0; w < 2; w++) m_t[w] = 0;
        if0.i_lock = 0; if0.i_btn = 0; if0.i_cnt = 0; if0.i_cnt_cw = 0;
        if1.i_lock = 0; if1.i_btn = 0; if1.i_cnt = 0; if1.i_cnt_cw = 0;

        // Reset and navigation
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        chk("rst_values", 64'(if0.o_values), 64'h32323232);
        chk("rst_edit", 64'(if0.o_edit), 64'd0);
        repeat (5) cycle(0, 0, 0, 1, 1);
        chk("nav_cw5", 64'(if0.o_sel), 64'd1);
        cycle(0, 0, 0, 1, 0);
        chk("nav_ccw1", 64'(if0.o_sel), 64'd0);
        cycle(0, 0, 0, 1, 0);
        chk("nav_ccw_wrap", 64'(if0.o_sel), 64'd3);

        // Slow edit steps
        cycle(0, 0, 1, 0, 0);
        chk("edit_enter", 64'(if0.o_edit), 64'd1);
        for (int i = 0; i < 3; i++) begin
            idle(499);
            cycle(0, 0, 0, 1, 1);
            chk($sformatf("slow_step%0d", i), 64'(if0.o_value), 64'(51 + i));
            chk($sformatf("slow_pulse%0d", i), 64'(if0.o_changed), 64'd1);
        end

        // Acceleration and bounds
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 0);
        es(1); chk("acc_a", 64'(if0.o_value), 64'd51);
        es(1); chk("acc_b", 64'(if0.o_value), 64'd55);
        es(1); chk("acc_c", 64'(if0.o_value), 64'd59);
        es(0); chk("dirchg", 64'(if0.o_value), 64'd58);
        es(0); chk("acc_ccw", 64'(if0.o_value), 64'd54);
        es(1);
        repeat (11) es(1);
        chk("to99_w0", 64'(if0.o_value), 64'd99);
        chk("to99_w1", 64'(if1.o_value), 64'd99);
        es(1);
        chk("sat_hi", 64'(if0.o_value), 64'd100);
        chk("sat_hi_pulse", 64'(if0.o_changed), 64'd1);
        chk("wrap_hi", 64'(if1.o_value), 64'd0);
        es(0);
        chk("wrap_lo", 64'(if1.o_value), 64'd100);
        es(1);
        es(1);
        chk("sat_hold", 64'(if0.o_value), 64'd100);
        chk("sat_no_pulse", 64'(if0.o_changed), 64'd0);
        chk("wrap_fast", 64'(if1.o_value), 64'd4);

        // Button beats encoder; idle timeout
        v_before = if0.o_value;
        s_before = if0.o_sel;
        cycle(0, 0, 1, 1, 1);
        chk("prio_edit", 64'(if0.o_edit), 64'd0);
        chk("prio_value", 64'(if0.o_value), 64'(v_before));
        chk("prio_sel", 64'(if0.o_sel), 64'(s_before));
        cycle(0, 0, 1, 0, 0);
        idle(IT - 1);
        chk("timeout_pre", 64'(if0.o_edit), 64'd1);
        idle(1);
        chk("timeout_at", 64'(if0.o_edit), 64'd0);

        // Lock and mid-edit reset
        cycle(0, 0, 0, 1, 1);
        cycle(0, 0, 1, 0, 0);
        snap = if0.o_values;
        for (int i = 0; i < 20; i++)
            cycle(0, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        chk("lock_values", 64'(if0.o_values), 64'(snap));
        chk("lock_edit", 64'(if0.o_edit), 64'd1);
        chk("lock_sel", 64'(if0.o_sel), 64'd1);
        idle(1);
        chk("unlock_no_pulse", 64'(if0.o_changed), 64'd0);
        es(1);
        cycle(1, 0, 0, 0, 0);
        chk("rst_mid_edit", 64'(if0.o_edit), 64'd0);
        chk("rst_mid_sel", 64'(if0.o_sel), 64'd0);
        chk("rst_mid_vals", 64'(if0.o_values), 64'h32323232);
        chk("rst_mid_chg", 64'(if0.o_changed), 64'd0);

        // Randomized traffic
        for (int e = 0; e < 200; e++) begin
            int cat, gap, kind;
            bit lk;
            cat = $urandom_range(0, 9);
            if (cat < 5)      gap = $urandom_range(1, 12);
            else if (cat < 8) gap = $urandom_range(95, 105);
            else if (cat < 9) gap = $urandom_range(200, 400);
            else              gap = $urandom_range(990, 1010);
            for (int g = 0; g < gap; g++)
                cycle(0, ($urandom_range(0, 15) == 0), 0, 0, 0);
            kind = $urandom_range(0, 19);
            lk = ($urandom_range(0, 9) == 0);
            if (kind < 14)      cycle(0, lk, 0, 1, 1'($urandom_range(0, 1)));
            else if (kind < 17) cycle(0, lk, 1, 0, 0);
            else if (kind < 19) cycle(0, lk, 1, 1, 1'($urandom_range(0, 1)));
            else                cycle(1, 0, 0, 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/rotary_param_ctrl.md
Name: rotary_param_ctrl

Overview:
Consumes the step pulses from the synchronous incremental rotary encoder driver and a debounced push-button pulse, and shares that single encoder among N_PARAMS parameter registers. A two-state controller alternates between navigating, where the encoder selects a parameter, and editing, where the encoder changes the selected value. Editing supports saturate or wrap bounds, speed acceleration and an inactivity timeout. Sits between the encoder driver and user-configurable datapath settings such as volume, PWM duty and menu values.

Parameters:
N_PARAMS, 4, number of parameter registers (2..16)
WIDTH, 8, bits per parameter
MIN_VAL, 0, lower bound of every parameter
MAX_VAL, 100, upper bound of every parameter; MIN_VAL <= RESET_VAL <= MAX_VAL < 2^WIDTH
RESET_VAL, 50, value of every parameter after reset
WRAP, 0, 0 = saturate at bounds, 1 = wrap past a bound to the opposite bound
ACCEL_WINDOW, 50000, maximum cycles between same-direction steps that still counts as fast rotation
ACCEL_STEP, 4, step size during fast rotation (1 <= ACCEL_STEP <= MAX_VAL-MIN_VAL)
IDLE_TIMEOUT, 10000000, cycles without an encoder step before EDIT returns to NAV

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous reset, active-high
i_cnt  in  1  one-cycle encoder step pulse
i_cnt_cw  in  1  step direction, valid only with i_cnt; 1 = clockwise = increment
i_btn  in  1  one-cycle debounced button pulse
i_lock  in  1  level; while high, all i_cnt and i_btn pulses are discarded and timers hold
o_sel  out  clog2(N_PARAMS)  index of the selected parameter
o_edit  out  1  1 = EDIT state
o_value  out  WIDTH  value of the selected parameter
o_values  out  N_PARAMS*WIDTH  all parameters; parameter k is at bits [k*WIDTH +: WIDTH]
o_changed  out  1  one-cycle pulse when a parameter value actually changed

Behaviour:
- Reset (i_rst sampled high at an edge):
  - All parameters = RESET_VAL; o_sel = 0; state NAV; o_edit = 0; o_changed = 0.
  - Acceleration interval counter saturated at ACCEL_WINDOW; last direction = 0; idle counter = 0.
  - Reset mid-edit discards the operation in progress.
- All inputs are sampled at the rising edge. The outputs update at that same edge, so latency is 1 clock from the pulse to the visible effect.
- State machine:
  - NAV: i_btn -> EDIT, and the idle counter clears. i_cnt with i_cnt_cw=1 -> o_sel+1, wrapping from N_PARAMS-1 to 0. i_cnt with i_cnt_cw=0 -> o_sel-1, wrapping from 0 to N_PARAMS-1. No acceleration applies in NAV.
  - EDIT: i_btn -> NAV. i_cnt -> the selected value changes by +/-step and the idle counter clears. Otherwise the idle counter increments. When the idle counter reaches IDLE_TIMEOUT-1 -> NAV.
- Simultaneous i_btn and i_cnt in the same cycle: the button takes priority, the step is discarded, and no counter updates from that step.
- Step size (EDIT only):
  - step = ACCEL_STEP if the interval counter < ACCEL_WINDOW and i_cnt_cw equals the last direction; otherwise step = 1.
  - On every accepted EDIT step, the interval counter clears to 0 and the last direction becomes i_cnt_cw.
  - Otherwise the interval counter increments and saturates at ACCEL_WINDOW.
  - Entering EDIT saturates the interval counter, so the first step of an edit is always 1.
- Arithmetic:
  - Compute in WIDTH+2 bits so that no intermediate overflows.
  - WRAP=0: a result above MAX_VAL clamps to MAX_VAL; a result below MIN_VAL clamps to MIN_VAL.
  - WRAP=1: a result above MAX_VAL becomes MIN_VAL; a result below MIN_VAL becomes MAX_VAL. This is not modular; the remainder is discarded.
- o_changed is high for exactly the one cycle after the edge where the stored value differed from its previous value. A clamped step at a bound produces no pulse. o_sel changes and state changes never pulse o_changed.
- o_value and o_values are registered, never combinational from the inputs.
- i_lock high:
  - State, o_sel, all values, the interval counter and the idle counter all hold.
  - o_changed = 0.
  - Releasing i_lock resumes operation with no pulse replay.

Test Plan:
Bench parameters: N_PARAMS=4, WIDTH=8, MIN_VAL=0, MAX_VAL=100, RESET_VAL=50, ACCEL_WINDOW=100, ACCEL_STEP=4, IDLE_TIMEOUT=1000.
1. Reset, then 5 cw steps in NAV -> o_sel 1,2,3,0,1. 1 ccw step -> o_sel 0. 1 more ccw step -> o_sel 3. o_changed never asserts; all values stay 50.
2. i_btn, then 3 cw steps 500 cycles apart -> o_edit=1; value 51,52,53 (step=1 each); o_changed one cycle per step, landing on the same edge as the value update.
3. In EDIT, cw steps 10 cycles apart -> 51,55,59. A ccw step 10 cycles later -> 58 (direction change forces step=1). A further ccw step 10 cycles later -> 54.
4. Drive the value to 99, then a fast cw step (step=4) -> 100 with a pulse; another -> 100 with no o_changed. With WRAP=1, from 99 a fast cw step -> 0; from 0 a ccw step -> 100.
5. i_btn and i_cnt in the same cycle while in EDIT -> state NAV, value unchanged, o_sel unchanged. In EDIT with no step for 1000 cycles -> o_edit=0 exactly at cycle 1000.
6. Hold i_lock with pulses on i_cnt and i_btn -> no output change. Assert i_rst mid-EDIT -> next cycle o_edit=0, o_sel=0, all values 50, o_changed=0.
